dual_clock_fifo: RTL and testbench
==================================

// Module: dual_clock_fifo
// PURPOSE
// - Asynchronous dual-clock FIFO for the audio/FFT/CPU data path: audio samples into the FFT domain,
//   FFT results to audio out, FFT results to the CPU bus.
// - Write side runs on aud_clk; read side runs on an independent rd_clk.
// - Pointers cross domains as Gray code through 2-flop synchronizers.
// - Each side reports its own pessimistic fill level.
// PARAMETERS
// - DATA_W  16     word width (32 for the CPU instance)
// - ADDR_W  14     log2 of depth; DEPTH = 2**ADDR_W (16384 default, so an 8192-sample frame fits)
// - USED_W  16     width of the usedw outputs; must be >= ADDR_W+1; zero-extended
// PORTS
// - aud_clk  in   1       write clock
// - reset    in   1       synchronous, active-high, sampled on aud_clk
// - rd_clk   in   1       read clock, asynchronous to aud_clk
// - wrreq    in   1       write request, aud_clk domain
// - data     in   DATA_W  write data
// - wrfull   out  1       FIFO full (write view)
// - wrusedw  out  USED_W  words stored (write view)
// - rdreq    in   1       read request, rd_clk domain
// - q        out  DATA_W  read data
// - rdempty  out  1       FIFO empty (read view)
// - rdusedw  out  USED_W  words stored (read view)
// BEHAVIOUR
// - Storage: DEPTH x DATA_W dual-port RAM. Written on aud_clk, read on rd_clk.
// - Pointers: ADDR_W+1 bits binary plus a Gray mirror on each side. The extra MSB separates full from empty.
// - Reset:
//   - reset sampled high on aud_clk: wr pointers=0, wrfull=0, wrusedw=0 on that edge.
//   - Read side uses rd_rst, which is reset passed through a 2-flop rd_clk synchronizer.
//   - rd_rst: rd pointers=0, q=0, rdempty=1, rdusedw=0.
//   - Both synchronizer chains clear to 0.
//   - Read-side reset lags by <=3 rd_clk edges; rdreq during that window is ignored.
//   - Mid-operation reset discards all contents. No read may return pre-reset data once rd_rst has been applied.
// - Write: on aud_clk, if wrreq && !wrfull && !reset: mem[wptr]<=data, wptr++.
//   - wrreq while wrfull is dropped silently; the pointer does not move.
// - Read (normal mode): on rd_clk, if rdreq && !rdempty: q<=mem[rptr], rptr++.
//   - q is valid the edge after the accepted rdreq and holds until the next accepted read.
//   - rdreq while empty is ignored; q holds.
// - Full/empty:
//   - wrfull = (wgray_next == {~rgray_sync[top2], rgray_sync[rest]}), registered.
//   - rdempty = (rgray_next == wgray_sync), registered.
// - Usedw:
//   - wrusedw = wptr - bin(rgray_sync). Counts high (pessimistic), so writes never overflow.
//   - rdusedw = bin(wgray_sync) - rptr. Counts low (pessimistic), so reads never underflow.
//   - Both are registered, range 0..DEPTH, and zero-extended to USED_W.
// - Latency:
//   - A write becomes visible to rdempty/rdusedw within 3 rd_clk edges.
//   - A read frees space in wrfull/wrusedw within 3 aud_clk edges.
// - Wrap-around: pointer MSB toggles every DEPTH words. The ordering of data is preserved across the wrap.
// - Simultaneous write and read on the same location: the read returns the old word. A read is only
//   accepted after the pointer has synchronized, so no hazard arises.
// - Clock ratio: any. No clock may be assumed faster than the other.
// CONFIGURATION
// - Macro DC_FIFO_SHOWAHEAD_EN.
//   - Defined: first-word-fall-through. q presents the head word whenever !rdempty.
//     rdreq acknowledges it, and the next word appears the following edge.
//     rdempty deasserts one rd_clk later than in normal mode, on the edge the head word is
//     prefetched into the output register.
//   - Undefined: normal mode as described above.
// TESTING
// - Reset: assert reset 2 aud_clk cycles, then idle 4 rd_clk cycles.
//   -> rdempty=1, wrfull=0, rdusedw=0, wrusedw=0, q=0.
// - Ordered transfer: write 0x0001..0x0010 (16 words) at aud_clk=12.288MHz, rd_clk=50MHz;
//   read all 16 -> q sequence 0x0001..0x0010, then rdempty=1, rdusedw=0.
// - Fill: write DEPTH words without reading -> wrfull=1, wrusedw=DEPTH.
//   Write 0xDEAD while full -> ignored. Read DEPTH words -> last q = word DEPTH and 0xDEAD never appears.
// - Frame threshold: write 8192 words -> rdusedw reaches 8192 within 3 rd_clk edges of the last write.
//   It is never greater than the true count at any cycle.
// - Underflow: pulse rdreq 5 times while empty -> q unchanged, rdusedw stays 0, pointer unmoved.
//   The next written word 0x1234 reads back as 0x1234.
// - Wrap and reset: stream 3*DEPTH words with concurrent reads, rd_clk both 4x faster and 3x slower
//   -> no loss or duplication. Assert reset mid-stream -> after 3 rd_clk edges rdempty=1, and subsequent
//   data 0x00AA is the first word read.

Source files
------------

// File: rtl/dual_clock_fifo.sv
// dual_clock_fifo: Gray-pointer async FIFO, written on aud_clk, read on rd_clk.
// Define DC_FIFO_SHOWAHEAD_EN for first-word-fall-through reads.
`timescale 1ns/1ps
module dual_clock_fifo #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 14,
   parameter int USED_W = 16
) (
   input  logic              aud_clk,
   input  logic              reset,
   input  logic              rd_clk,
   input  logic              wrreq,
   input  logic [DATA_W-1:0] data,
   output logic              wrfull,
   output logic [USED_W-1:0] wrusedw,
   input  logic              rdreq,
   output logic [DATA_W-1:0] q,
   output logic              rdempty,
   output logic [USED_W-1:0] rdusedw
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int PW    = ADDR_W + 1;

   function automatic logic [PW-1:0] f_b2g(input logic [PW-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [PW-1:0] f_g2b(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [PW-1:0] r_wbin;
   logic [PW-1:0] r_wgray;
   logic [PW-1:0] r_rgray_s1;
   logic [PW-1:0] r_rgray_s2;
   logic [PW-1:0] r_wused;
   logic          r_wfull;
   logic          w_wr_en;
   logic [PW-1:0] w_wbin_nxt;
   logic [PW-1:0] w_wgray_nxt;
   logic [PW-1:0] w_rgray_inv;

   logic [PW-1:0] r_rbin;
   logic [PW-1:0] r_rgray;
   logic [PW-1:0] r_wgray_s1;
   logic [PW-1:0] r_wgray_s2;
   logic [PW-1:0] r_rused;
   logic          r_rempty;
   logic          r_rst_s1;
   logic          r_rst_s2;
   logic [DATA_W-1:0] r_q;
   logic          w_rd_hold;
   logic          w_rd_en;
   logic [PW-1:0] w_rbin_nxt;
   logic [PW-1:0] w_rgray_nxt;

   // ---------------- write domain ----------------
   assign w_wr_en     = wrreq && !r_wfull;
   assign w_wbin_nxt  = r_wbin + PW'(w_wr_en);
   assign w_wgray_nxt = f_b2g(w_wbin_nxt);
   assign w_rgray_inv = {~r_rgray_s2[PW-1:PW-2], r_rgray_s2[PW-3:0]};

   always_ff @(posedge aud_clk) begin
      if (reset) begin
         r_wbin     <= '0;
         r_wgray    <= '0;
         r_rgray_s1 <= '0;
         r_rgray_s2 <= '0;
         r_wfull    <= 1'b0;
         r_wused    <= '0;
      end else begin
         r_rgray_s1 <= r_rgray;
         r_rgray_s2 <= r_rgray_s1;
         r_wbin     <= w_wbin_nxt;
         r_wgray    <= w_wgray_nxt;
         r_wfull    <= (w_wgray_nxt == w_rgray_inv);
         r_wused    <= w_wbin_nxt - f_g2b(r_rgray_s2);
      end
   end

   always_ff @(posedge aud_clk) begin
      if (w_wr_en && !reset) r_mem[r_wbin[ADDR_W-1:0]] <= data;
   end

   assign wrfull  = r_wfull;
   assign wrusedw = USED_W'(r_wused);

   // ---------------- read domain ----------------
   always_ff @(posedge rd_clk) begin
      r_rst_s1 <= reset;
      r_rst_s2 <= r_rst_s1;
   end

   // Reads stall from the first synchronized reset sample until rd_rst lands.
   assign w_rd_hold = r_rst_s1 || r_rst_s2;

`ifdef DC_FIFO_SHOWAHEAD_EN
   logic r_ovalid;
   assign w_rd_en = !r_rempty && !w_rd_hold && (!r_ovalid || rdreq);

   always_ff @(posedge rd_clk) begin
      if (r_rst_s2)                    r_ovalid <= 1'b0;
      else if (w_rd_en)                r_ovalid <= 1'b1;
      else if (rdreq && !w_rd_hold)    r_ovalid <= 1'b0;
   end

   assign rdempty = !r_ovalid;
`else
   assign w_rd_en = rdreq && !r_rempty && !w_rd_hold;
   assign rdempty = r_rempty;
`endif

   assign w_rbin_nxt  = r_rbin + PW'(w_rd_en);
   assign w_rgray_nxt = f_b2g(w_rbin_nxt);

   always_ff @(posedge rd_clk) begin
      if (r_rst_s2) begin
         r_rbin     <= '0;
         r_rgray    <= '0;
         r_wgray_s1 <= '0;
         r_wgray_s2 <= '0;
         r_rempty   <= 1'b1;
         r_rused    <= '0;
         r_q        <= '0;
      end else begin
         r_wgray_s1 <= r_wgray;
         r_wgray_s2 <= r_wgray_s1;
         r_rbin     <= w_rbin_nxt;
         r_rgray    <= w_rgray_nxt;
         r_rempty   <= (w_rgray_nxt == r_wgray_s2);
         r_rused    <= f_g2b(r_wgray_s2) - w_rbin_nxt;
         if (w_rd_en) r_q <= r_mem[r_rbin[ADDR_W-1:0]];
      end
   end

   assign q       = r_q;
   assign rdusedw = USED_W'(r_rused);

endmodule

// File: tb/tb_dual_clock_fifo.sv
// tb_dual_clock_fifo: scoreboard bench for dual_clock_fifo on a small depth.
// Frame threshold is scaled to DEPTH/2 to keep the run short.
`timescale 1ns/1ps
module tb_dual_clock_fifo;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int USED_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int FRAME  = DEPTH / 2;
   localparam int BOUND  = 400;

   logic              aud_clk = 1'b0;
   logic              rd_clk  = 1'b0;
   logic              reset   = 1'b0;
   logic              wrreq   = 1'b0;
   logic [DATA_W-1:0] data    = '0;
   logic              wrfull;
   logic [USED_W-1:0] wrusedw;
   logic              rdreq   = 1'b0;
   logic [DATA_W-1:0] q;
   logic              rdempty;
   logic [USED_W-1:0] rdusedw;

   int aud_half = 41;
   int rd_half  = 10;
   int n_chk    = 0;
   int n_err    = 0;
   logic [DATA_W-1:0] exp_q [$];

   always #(aud_half) aud_clk = ~aud_clk;
   always #(rd_half)  rd_clk  = ~rd_clk;

   dual_clock_fifo #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .USED_W(USED_W)
   ) dut (
      .aud_clk(aud_clk), .reset(reset), .rd_clk(rd_clk),
      .wrreq(wrreq), .data(data), .wrfull(wrfull), .wrusedw(wrusedw),
      .rdreq(rdreq), .q(q), .rdempty(rdempty), .rdusedw(rdusedw)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_word(input logic [DATA_W-1:0] d);
      int t = 0;
      @(negedge aud_clk);
      wrreq = 1'b1;
      data  = d;
      while (wrfull && t < BOUND) begin
         t++;
         @(negedge aud_clk);
      end
      if (wrfull) begin
         chk("wr_timeout", 32'(wrfull), 0);
         wrreq = 1'b0;
         return;
      end
      exp_q.push_back(d);
      @(posedge aud_clk);
      #1 wrreq = 1'b0;
   endtask

   task automatic rd_word();
      int t = 0;
      logic [DATA_W-1:0] e;
      @(negedge rd_clk);
      while (rdempty && t < BOUND) begin
         t++;
         @(negedge rd_clk);
      end
      if (rdempty) begin
         chk("rd_timeout", 32'(rdempty), 0);
         return;
      end
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      rdreq = 1'b1;
`ifdef DC_FIFO_SHOWAHEAD_EN
      chk("q", 32'(q), 32'(e));
      @(posedge rd_clk);
      #1 rdreq = 1'b0;
`else
      @(posedge rd_clk);
      #1 rdreq = 1'b0;
      chk("q", 32'(q), 32'(e));
`endif
   endtask

   task automatic stream(input int n, input logic [DATA_W-1:0] base);
      fork
         for (int i = 0; i < n; i++) wr_word(base + DATA_W'(i));
         for (int i = 0; i < n; i++) rd_word();
      join
      chk("sb_drained", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit wr_done;

      // reset state
      @(negedge aud_clk);
      reset = 1'b1;
      repeat (2) @(negedge aud_clk);
      reset = 1'b0;
      repeat (4) @(negedge rd_clk);
      chk("rst_rdempty", 32'(rdempty), 1);
      chk("rst_wrfull",  32'(wrfull),  0);
      chk("rst_rdusedw", 32'(rdusedw), 0);
      chk("rst_wrusedw", 32'(wrusedw), 0);
      chk("rst_q",       32'(q),       0);

      // ordered transfer
      for (int i = 1; i <= 16; i++) wr_word(DATA_W'(i));
      for (int i = 0; i < 16; i++) rd_word();
      repeat (4) @(negedge rd_clk);
      chk("ord_rdempty", 32'(rdempty), 1);
      chk("ord_rdusedw", 32'(rdusedw), 0);

      // underflow
      for (int i = 0; i < 5; i++) begin
         @(negedge rd_clk);
         rdreq = 1'b1;
         @(posedge rd_clk);
         #1 rdreq = 1'b0;
      end
      @(negedge rd_clk);
      chk("uf_q",       32'(q),       32'h0010);
      chk("uf_rdusedw", 32'(rdusedw), 0);
      chk("uf_rdempty", 32'(rdempty), 1);
      wr_word(16'h1234);
      rd_word();
      repeat (4) @(negedge aud_clk);

      // fill
      for (int i = 0; i < DEPTH; i++) wr_word(16'h0100 + DATA_W'(i));
      @(negedge aud_clk);
      chk("fill_wrfull",  32'(wrfull),  1);
      chk("fill_wrusedw", 32'(wrusedw), DEPTH);
      wrreq = 1'b1;
      data  = 16'hDEAD;
      @(posedge aud_clk);
      #1 wrreq = 1'b0;
      @(negedge aud_clk);
      chk("full_wrusedw", 32'(wrusedw), DEPTH);
      for (int i = 0; i < DEPTH; i++) rd_word();
      chk("fill_last_q", 32'(q), 32'h0100 + DEPTH - 1);
      repeat (4) @(negedge rd_clk);
      chk("fill_rdempty", 32'(rdempty), 1);

      // frame threshold with pessimism monitor
      wr_done = 1'b0;
      fork
         begin
            for (int i = 0; i < FRAME; i++) wr_word(16'h2000 + DATA_W'(i));
            wr_done = 1'b1;
         end
         while (!wr_done) begin
            @(negedge rd_clk);
            chk("frm_rdusedw_le", 32'(32'(rdusedw) <= exp_q.size()), 1);
         end
      join
      repeat (3) @(posedge rd_clk);
      #1 chk("frm_rdusedw", 32'(rdusedw), FRAME);
      for (int i = 0; i < FRAME; i++) rd_word();

      // wrap with rd_clk 4x faster, then 3x slower
      stream(3 * DEPTH, 16'h3000);
      rd_half = 3 * aud_half;
      repeat (2) @(negedge rd_clk);
      stream(3 * DEPTH, 16'h4000);
      rd_half = 10;
      repeat (2) @(negedge rd_clk);

      // reset mid-stream
      fork
         for (int i = 0; i < 20; i++) wr_word(16'h5000 + DATA_W'(i));
         for (int i = 0; i < 10; i++) rd_word();
      join
      @(negedge aud_clk);
      reset = 1'b1;
      exp_q.delete();
      repeat (3) @(posedge rd_clk);
      #1;
      chk("mrst_rdempty", 32'(rdempty), 1);
      chk("mrst_rdusedw", 32'(rdusedw), 0);
      repeat (2) @(negedge aud_clk);
      reset = 1'b0;
      repeat (8) @(negedge aud_clk);
      chk("mrst_wrusedw", 32'(wrusedw), 0);
      chk("mrst_wrfull",  32'(wrfull),  0);
      wr_word(16'h00AA);
      rd_word();
      chk("mrst_first_q", 32'(q), 32'h00AA);
      repeat (4) @(negedge rd_clk);
      chk("mrst_end_empty", 32'(rdempty), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
